tl_bypass_switch: RTL

//  Parametrised TL-UL bypass switch placed in front of a slave device (e.g. the debug/DMI port).
//  In PASS mode it forwards A requests and D responses unchanged.
//  In BYPASS mode it terminates requests in an internal error responder that returns denied.

---
 rtl/tl_bypass_switch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/tl_bypass_switch.sv
// tl_bypass_switch: TL-UL pass/bypass switch with drain-safe mode changes and an error responder; optional denied counter under TL_BYPASS_STATS_EN
module tl_bypass_switch #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 2,
  parameter int SRC_W = 1,
  parameter int MAX_INFLIGHT = 4,
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              in_a_ready,
  input  logic              in_a_valid,
  input  logic [2:0]        in_a_opcode,
  input  logic [SIZE_W-1:0] in_a_size,
  input  logic [SRC_W-1:0]  in_a_source,
  input  logic [ADDR_W-1:0] in_a_address,
  input  logic [DATA_W-1:0] in_a_data,
  input  logic              in_d_ready,
  output logic              in_d_valid,
  output logic [2:0]        in_d_opcode,
  output logic [1:0]        in_d_param,
  output logic [SIZE_W-1:0] in_d_size,
  output logic [SRC_W-1:0]  in_d_source,
  output logic              in_d_sink,
  output logic              in_d_denied,
  output logic              in_d_corrupt,
  output logic [DATA_W-1:0] in_d_data,
  input  logic              out_a_ready,
  output logic              out_a_valid,
  output logic [2:0]        out_a_opcode,
  output logic [SIZE_W-1:0] out_a_size,
  output logic [SRC_W-1:0]  out_a_source,
  output logic [ADDR_W-1:0] out_a_address,
  output logic [DATA_W-1:0] out_a_data,
  output logic              out_d_ready,
  input  logic              out_d_valid,
  input  logic [2:0]        out_d_opcode,
  input  logic [1:0]        out_d_param,
  input  logic [SIZE_W-1:0] out_d_size,
  input  logic [SRC_W-1:0]  out_d_source,
  input  logic              out_d_sink,
  input  logic              out_d_denied,
  input  logic              out_d_corrupt,
  input  logic [DATA_W-1:0] out_d_data,
  input  logic              io_bypass,
  output logic              io_bypassed,
  output logic [CNT_W-1:0]  io_inflight
`ifdef TL_BYPASS_STATS_EN
  ,
  output logic [15:0]       io_denied_cnt
`endif
);
  typedef enum logic [1:0] {PASS, DRAIN_TO_BYP, BYPASS, DRAIN_TO_PASS} state_t;
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic err_full, err_get;
  logic [SIZE_W-1:0] err_size;
  logic [SRC_W-1:0] err_src;
  logic space, route, a_dn_fire, d_dn_fire, err_a_fire, err_d_fire;
  assign out_a_opcode = in_a_opcode;
  assign out_a_size = in_a_size;
  assign out_a_source = in_a_source;
  assign out_a_address = in_a_address;
  assign out_a_data = in_a_data;
  assign space = cnt < CNT_W'(MAX_INFLIGHT);
  // Downstream keeps the upstream D channel until every PASS transaction has returned
  assign route = st == PASS || cnt != '0;
  assign a_dn_fire = out_a_valid && out_a_ready;
  assign d_dn_fire = out_d_valid && out_d_ready;
  assign err_a_fire = st == BYPASS && in_a_valid && in_a_ready;
  assign err_d_fire = !route && in_d_valid && in_d_ready;
  assign io_bypassed = st == BYPASS;
  assign io_inflight = cnt;
  always_comb begin
    nxt = st;
    unique case (st)
      PASS:          nxt = io_bypass ? DRAIN_TO_BYP : PASS;
      DRAIN_TO_BYP:  nxt = cnt == '0 ? BYPASS : (!io_bypass ? PASS : DRAIN_TO_BYP);
      BYPASS:        nxt = io_bypass ? BYPASS : DRAIN_TO_PASS;
      DRAIN_TO_PASS: nxt = !err_full ? PASS : (io_bypass ? BYPASS : DRAIN_TO_PASS);
    endcase
  end
  always_comb begin
    out_a_valid = !reset && st == PASS && in_a_valid && space;
    in_a_ready = !reset && (st == PASS ? out_a_ready && space : st == BYPASS && (!err_full || in_d_ready));
    out_d_ready = !reset && route && in_d_ready;
    in_d_valid = !reset && (route ? out_d_valid : err_full);
    in_d_opcode = route ? out_d_opcode : {2'b00, err_get};
    in_d_param = route ? out_d_param : 2'b00;
    in_d_size = route ? out_d_size : err_size;
    in_d_source = route ? out_d_source : err_src;
    in_d_sink = route && out_d_sink;
    in_d_denied = !route || out_d_denied;
    in_d_corrupt = route ? out_d_corrupt : err_get;
    in_d_data = route ? out_d_data : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= PASS;
      cnt <= '0;
      err_full <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= cnt + CNT_W'(a_dn_fire) - CNT_W'(d_dn_fire && cnt != '0);
      if (err_a_fire) err_full <= 1'b1;
      else if (err_d_fire) err_full <= 1'b0;
    end
  end
  // Anything other than PutFull/PutPartial is answered like a Get
  always_ff @(posedge clock) begin
    if (err_a_fire) begin
      err_get <= in_a_opcode[2:1] != 2'b00;
      err_size <= in_a_size;
      err_src <= in_a_source;
    end
  end
  a_no_d_underflow: assert property (@(posedge clock) disable iff (reset) !(d_dn_fire && cnt == '0));
`ifdef TL_BYPASS_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) io_denied_cnt <= '0;
    else if (err_d_fire && io_denied_cnt != 16'hFFFF) io_denied_cnt <= io_denied_cnt + 16'd1;
  end
`endif
endmodule
